// File: rtl/fb_arbiter.sv
// Framebuffer arbiter: VGA scanout > clear sequencer > game-logic writes.
// Optional FB_VBLANK_ONLY_EN restricts writes and clears to vertical blanking.
module fb_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vga_rd_i,
  input  logic [ADDR_W-1:0] vga_addr_i,
  output logic [DATA_W-1:0] vga_data_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ack_o,
  input  logic              clr_start_i,
  input  logic [DATA_W-1:0] clr_color_i,
  output logic              clr_busy_o,
  input  logic              vblank_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] color_q;
  logic              rd_pend_q;
  logic [DATA_W-1:0] vga_data_q;

  logic vb_ok;
  logic busy;
  logic gnt_vga;
  logic gnt_clr;
  logic gnt_wr;

`ifdef FB_VBLANK_ONLY_EN
  assign vb_ok = vblank_i;
`else
  logic unused_vblank;
  assign unused_vblank = vblank_i;
  assign vb_ok = 1'b1;
`endif

  assign busy = (state_q == CLEAR);

  // Grants are masked by rst so the RAM port goes quiet the instant reset hits
  always_comb begin
    gnt_vga = ~rst_i & vga_rd_i;
    gnt_clr = ~rst_i & ~vga_rd_i & busy & vb_ok;
    gnt_wr  = ~rst_i & ~vga_rd_i & ~busy & ~clr_start_i
            & wr_req_i & vb_ok;
  end

  always_comb begin
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_wdata_o = '0;
    unique case (1'b1)
      gnt_vga: begin
        ram_addr_o = vga_addr_i;
      end
      gnt_clr: begin
        ram_addr_o  = cnt_q;
        ram_we_o    = 1'b1;
        ram_wdata_o = color_q;
      end
      gnt_wr: begin
        ram_addr_o  = wr_addr_i;
        ram_we_o    = 1'b1;
        ram_wdata_o = wr_data_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      color_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clr_start_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            color_q <= clr_color_i;
          end
        end
        CLEAR: begin
          if (gnt_clr) begin
            if (cnt_q == LAST) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM read data lands one cycle after the grant; capture it then
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_pend_q  <= 1'b0;
      vga_data_q <= '0;
    end else begin
      rd_pend_q <= gnt_vga;
      if (rd_pend_q) begin
        vga_data_q <= ram_rdata_i;
      end
    end
  end

  assign vga_data_o = vga_data_q;
  assign wr_ack_o   = gnt_wr;
  assign clr_busy_o = busy;

endmodule

// File: tb/tb_fb_arbiter.sv
// Randomized bench for fb_arbiter against a cell-level framebuffer model.
// Models the RAM, tracks expected contents, grants and scanout data.
module tb_fb_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       vga_rd;
  logic [8:0] vga_addr;
  logic [7:0] vga_data;
  logic       wr_req;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       clr_start;
  logic [7:0] clr_color;
  logic       clr_busy;
  logic       vblank;
  logic [8:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  fb_arbiter #(.ADDR_W(9), .DATA_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .vga_rd_i    (vga_rd),
    .vga_addr_i  (vga_addr),
    .vga_data_o  (vga_data),
    .wr_req_i    (wr_req),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_ack_o    (wr_ack),
    .clr_start_i (clr_start),
    .clr_color_i (clr_color),
    .clr_busy_o  (clr_busy),
    .vblank_i    (vblank),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [512];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ref_fb [512];
  int         clr_left = 0;
  logic [7:0] clr_col  = 8'h00;
  logic       last_ack = 1'b0;
  logic       p1v = 1'b0, p2v = 1'b0;
  logic [7:0] p1d = 8'h00, p2d = 8'h00;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic vb_ok_m();
`ifdef FB_VBLANK_ONLY_EN
    return vblank;
`else
    return 1'b1;
`endif
  endfunction

  // One clock cycle: check this cycle's grant, advance the model, clock.
  task automatic tick();
    logic       ea;
    logic       was_busy;
    logic       rv;
    logic [7:0] rd;
    #1;
    was_busy = (clr_left != 0);
    ea = wr_req && !vga_rd && !was_busy && !clr_start
         && vb_ok_m() && !rst;
    check("wr_ack", {31'd0, wr_ack}, {31'd0, ea});
    check("clr_busy", {31'd0, clr_busy}, {31'd0, was_busy});
    if (ea) begin
      check("wr_ram_addr", {23'd0, ram_addr}, {23'd0, wr_addr});
      check("wr_ram_data", {24'd0, ram_wdata}, {24'd0, wr_data});
    end
    rv = vga_rd;
    rd = ref_fb[vga_addr];
    if (vga_rd) begin
    end else if (was_busy && vb_ok_m()) begin
      ref_fb[512 - clr_left] = clr_col;
      clr_left--;
    end else if (ea) begin
      ref_fb[wr_addr] = wr_data;
    end
    if (!was_busy && clr_start) begin
      clr_left = 512;
      clr_col  = clr_color;
    end
    last_ack = ea;
    @(posedge clk);
    #1;
    p2v = p1v; p2d = p1d;
    p1v = rv;  p1d = rd;
    if (p2v) check("vga_data", {24'd0, vga_data}, {24'd0, p2d});
  endtask

  task automatic readback();
    for (int i = 0; i < 512; i++) begin
      vga_rd   = 1'b1;
      vga_addr = 9'(i);
      tick();
    end
    vga_rd = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (clr_busy && n < 3000) begin
      n++;
      tick();
    end
    check("clr_timeout", {31'd0, clr_busy}, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vga_data"}, {24'd0, vga_data}, 32'd0);
    check({tag, "_wr_ack"}, {31'd0, wr_ack}, 32'd0);
    check({tag, "_clr_busy"}, {31'd0, clr_busy}, 32'd0);
    check({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
    check({tag, "_ram_addr"}, {23'd0, ram_addr}, 32'd0);
    check({tag, "_ram_wdata"}, {24'd0, ram_wdata}, 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 512; i++) begin
      mem[i]    = 8'h00;
      ref_fb[i] = 8'h00;
    end
    rst = 1'b1;
    vga_rd = 1'b0; vga_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    clr_start = 1'b0; clr_color = '0;
    vblank = 1'b1;
    #3;
    check_zero("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Write then read back through scanout
    wr_req = 1'b1; wr_addr = 9'h010; wr_data = 8'hE0;
    #1;
    check("w1_ram_we", {31'd0, ram_we}, 32'd1);
    tick();
    wr_req = 1'b0;
    vga_rd = 1'b1; vga_addr = 9'h010;
    tick();
    vga_rd = 1'b0;
    tick();
    check("w1_readback", {24'd0, vga_data}, 32'hE0);

    // Scanout blocks the writer
    vga_rd = 1'b1; vga_addr = 9'h033;
    wr_req = 1'b1; wr_addr = 9'h0A5; wr_data = 8'h5A;
    for (int i = 0; i < 3; i++) tick();
    vga_rd = 1'b0;
    #1;
    check("prio_ack", {31'd0, wr_ack}, 32'd1);
    check("prio_addr", {23'd0, ram_addr}, 32'h0A5);
    tick();
    wr_req = 1'b0;
    tick();

    // Clear with a write colliding on the start cycle and held through it
    clr_start = 1'b1; clr_color = 8'h1C;
    wr_req = 1'b1; wr_addr = 9'h055; wr_data = 8'hAA;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (clr_busy && n < 3000) begin
      n++;
      tick();
    end
    check("clr_cycles", n, 512);
    #1;
    check("clr_post_ack", {31'd0, wr_ack}, 32'd1);
    tick();
    wr_req = 1'b0;
    readback();

    // Clear stalled by every-other-cycle scanout
    clr_start = 1'b1; clr_color = 8'h63;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (clr_busy && n < 3000) begin
      vga_rd   = ~n[0];
      vga_addr = 9'($urandom_range(0, 511));
      n++;
      tick();
    end
    vga_rd = 1'b0;
    check("stall_cycles", n, 1024);
    tick();
    tick();
    readback();

    // Reset in the middle of a clear
    clr_start = 1'b1; clr_color = 8'hC3;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    wr_req = 1'b1; wr_addr = 9'h1F0; wr_data = 8'h77;
    #2;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr_left = 0;
    p1v = 1'b0; p2v = 1'b0;
    tick();
    wr_req = 1'b0;
    readback();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      vga_rd   = ($urandom_range(0, 2) == 0);
      vga_addr = 9'($urandom_range(0, 511));
      vblank   = 1'($urandom_range(0, 1));
      if (!wr_req || last_ack) begin
        if ($urandom_range(0, 2) == 0) begin
          wr_req  = 1'b1;
          wr_addr = 9'($urandom_range(0, 511));
          wr_data = 8'($urandom_range(0, 255));
        end else begin
          wr_req = 1'b0;
        end
      end
      clr_start = ($urandom_range(0, 599) == 0);
      clr_color = 8'($urandom_range(0, 255));
      tick();
    end
    vga_rd = 1'b0; wr_req = 1'b0; clr_start = 1'b0; vblank = 1'b1;
    tick();
    wait_idle();
    readback();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
